ascon_seq_ctrl: RTL and testbench

Transaction sequencer sitting between a parallel host interface and the bit-serial Ascon core. It accepts one encrypt/decrypt request with parallel key/nonce/AD/data words, shifts the operands into the core MSB-first and waits for the core result. It then deserialises the ciphertext/plaintext and tag into parallel words and returns them with a status code. A watchdog and a protocol check guard against a hung or misbehaving core.

---
 rtl/ascon_ctrl_pkg.sv | 24 ++
 rtl/ascon_shift_reg.sv | 38 +++
 rtl/ascon_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ascon_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_pkg
// Shared types and constants for the Ascon transaction sequencer.
//   state_t    : sequencer states (IDLE, LOAD, WAIT, UNLOAD, RESP)
//   ST_*       : response status codes returned on rsp_status
//   W_DEFAULT  : default operand/result width in bits
// ---------------------------------------------------------------------------
package ascon_ctrl_pkg;

  localparam int W_DEFAULT = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    UNLOAD,
    RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_PROTO   = 2'b10;

endpackage

// File: rtl/ascon_shift_reg.sv
// ---------------------------------------------------------------------------
// ascon_shift_reg
// W-bit register with parallel load and shift-left by one with serial input.
// Parallel load has priority over shift.
//   clk, rst : clock, asynchronous active-high reset (clears the register)
//   load     : load din into the register
//   din      : parallel load value
//   shift    : shift left by one, sin enters at bit 0
//   sin      : serial input bit
//   q        : register contents (serial output is q[W-1])
// ---------------------------------------------------------------------------
module ascon_shift_reg
  import ascon_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/ascon_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_seq_ctrl
// Sequences one encrypt/decrypt transaction between a parallel host port and
// a bit-serial Ascon core: operands are shifted out MSB-first while
// core_start_o is high, the result and tag are shifted back in while
// core_ready_i is high, and a response with status is held for the host.
//   clk, rst        : clock, asynchronous active-high reset
//   req_*           : host request (valid/ready handshake, mode, operands)
//   rsp_*           : host response (valid/ready handshake, data, tag, status)
//   busy            : high whenever the sequencer is not idle
//   core_*_o        : serial operand bits, start strobe and mode to the core
//   core_output_i   : serial result bit from the core
//   core_tag_i      : serial tag bit from the core
//   core_ready_i    : core is streaming its result
// ---------------------------------------------------------------------------
module ascon_seq_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter  int W       = W_DEFAULT,
  parameter  int TIMEOUT = 4096,
  localparam int CNT_W   = $clog2(W + 1),
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_decrypt,
  input  logic [W-1:0] req_key,
  input  logic [W-1:0] req_nonce,
  input  logic [W-1:0] req_ad,
  input  logic [W-1:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] rsp_tag,
  output logic [1:0]   rsp_status,
  output logic         busy,
  output logic         core_key_o,
  output logic         core_nonce_o,
  output logic         core_ad_o,
  output logic         core_data_o,
  output logic         core_start_o,
  output logic         core_decrypt_o,
  input  logic         core_output_i,
  input  logic         core_tag_i,
  input  logic         core_ready_i
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  wdog;

  logic accept;
  logic op_shift;
  logic res_shift;

  logic [W-1:0] key_q, nonce_q, ad_q, data_q;

  assign accept    = req_valid && req_ready;
  assign op_shift  = (state == LOAD);
  // Result bits are captured on the first ready cycle seen in WAIT and on
  // every ready cycle of UNLOAD; UNLOAD is left right after the W-th capture.
  assign res_shift = core_ready_i && ((state == WAIT) || (state == UNLOAD));

  // Operand registers shift in zeros, so they are empty once LOAD finishes
  // and their MSBs can drive the serial lines directly in every state.
  ascon_shift_reg #(.W(W)) u_key (
    .clk(clk), .rst(rst), .load(accept), .din(req_key),
    .shift(op_shift), .sin(1'b0), .q(key_q)
  );
  ascon_shift_reg #(.W(W)) u_nonce (
    .clk(clk), .rst(rst), .load(accept), .din(req_nonce),
    .shift(op_shift), .sin(1'b0), .q(nonce_q)
  );
  ascon_shift_reg #(.W(W)) u_ad (
    .clk(clk), .rst(rst), .load(accept), .din(req_ad),
    .shift(op_shift), .sin(1'b0), .q(ad_q)
  );
  ascon_shift_reg #(.W(W)) u_data (
    .clk(clk), .rst(rst), .load(accept), .din(req_data),
    .shift(op_shift), .sin(1'b0), .q(data_q)
  );

  // Result registers are cleared on acceptance so a timeout returns zeros
  // and a protocol error returns only the bits actually captured.
  ascon_shift_reg #(.W(W)) u_rsp_data (
    .clk(clk), .rst(rst), .load(accept), .din('0),
    .shift(res_shift), .sin(core_output_i), .q(rsp_data)
  );
  ascon_shift_reg #(.W(W)) u_rsp_tag (
    .clk(clk), .rst(rst), .load(accept), .din('0),
    .shift(res_shift), .sin(core_tag_i), .q(rsp_tag)
  );

  assign core_key_o   = key_q[W-1];
  assign core_nonce_o = nonce_q[W-1];
  assign core_ad_o    = ad_q[W-1];
  assign core_data_o  = data_q[W-1];

  logic unused_op_lsbs;
  assign unused_op_lsbs = ^{key_q[W-2:0], nonce_q[W-2:0], ad_q[W-2:0], data_q[W-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wdog           <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_status     <= ST_OK;
      busy           <= 1'b0;
      core_start_o   <= 1'b0;
      core_decrypt_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= LOAD;
            cnt            <= '0;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            core_start_o   <= 1'b1;
            core_decrypt_o <= req_decrypt;
            rsp_status     <= ST_OK;
          end
        end
        LOAD: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            state        <= WAIT;
            core_start_o <= 1'b0;
            wdog         <= '0;
          end
        end
        WAIT: begin
          // Ready on the last permitted cycle still wins over the timeout.
          if (core_ready_i) begin
            state <= UNLOAD;
            cnt   <= CNT_W'(1);
          end else if (wdog == TO_W'(TIMEOUT - 1)) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end
        UNLOAD: begin
          if (!core_ready_i) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_PROTO;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(W - 1)) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_OK;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state          <= IDLE;
            rsp_valid      <= 1'b0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            core_decrypt_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_seq_ctrl
// Directed bench for ascon_seq_ctrl with W=8, TIMEOUT=16 and a behavioural
// serial core. Expected responses are queued when a request is issued and
// popped when the sequencer responds.
// ---------------------------------------------------------------------------
module tb_ascon_seq_ctrl;
  import ascon_ctrl_pkg::*;

  localparam int W       = 8;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_decrypt;
  logic [W-1:0] req_key, req_nonce, req_ad, req_data;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data, rsp_tag;
  logic [1:0]   rsp_status;
  logic         busy;
  logic         core_key_o, core_nonce_o, core_ad_o, core_data_o;
  logic         core_start_o, core_decrypt_o;
  logic         core_output_i, core_tag_i, core_ready_i;

  ascon_seq_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_status(rsp_status), .busy(busy),
    .core_key_o(core_key_o), .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o),
    .core_data_o(core_data_o), .core_start_o(core_start_o),
    .core_decrypt_o(core_decrypt_o), .core_output_i(core_output_i),
    .core_tag_i(core_tag_i), .core_ready_i(core_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] tag;
    logic [1:0]   status;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // Core model configuration: ready rises delay+2 edges after the core sees
  // start fall, and stays high for len cycles (0 = never responds).
  int           cfg_delay;
  int           cfg_len;
  logic [W-1:0] cfg_out, cfg_tag;

  // Operand bits seen by the core and number of start-high cycles.
  logic [W-1:0] cap_key, cap_nonce, cap_ad, cap_data;
  int           start_cnt;
  logic         start_prev;
  logic [W-1:0] sh_out, sh_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial core model.
  initial begin
    core_ready_i  = 1'b0;
    core_output_i = 1'b0;
    core_tag_i    = 1'b0;
    start_prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        start_prev = 1'b0;
      end else begin
        if (core_start_o) begin
          cap_key   = {cap_key[W-2:0], core_key_o};
          cap_nonce = {cap_nonce[W-2:0], core_nonce_o};
          cap_ad    = {cap_ad[W-2:0], core_ad_o};
          cap_data  = {cap_data[W-2:0], core_data_o};
          start_cnt++;
        end
        if (start_prev && !core_start_o && cfg_len > 0) begin
          sh_out = cfg_out;
          sh_tag = cfg_tag;
          repeat (cfg_delay + 2) @(posedge clk);
          for (int i = 0; i < cfg_len; i++) begin
            #1;
            core_ready_i  = 1'b1;
            core_output_i = sh_out[W-1];
            core_tag_i    = sh_tag[W-1];
            sh_out        = sh_out << 1;
            sh_tag        = sh_tag << 1;
            @(posedge clk);
          end
          #1;
          core_ready_i  = 1'b0;
          core_output_i = 1'b0;
          core_tag_i    = 1'b0;
        end
        start_prev = core_start_o;
      end
    end
  end

  task automatic set_core(input int delay, input int len, input logic [W-1:0] o, input logic [W-1:0] t);
    cfg_delay = delay;
    cfg_len   = len;
    cfg_out   = o;
    cfg_tag   = t;
  endtask

  // Reference behaviour of one transaction given how the core responds.
  function automatic exp_t model(input int len, input logic [W-1:0] o, input logic [W-1:0] t);
    exp_t e;
    if (len == 0) begin
      e.data = '0; e.tag = '0; e.status = ST_TIMEOUT;
    end else if (len >= W) begin
      e.data = o; e.tag = t; e.status = ST_OK;
    end else begin
      e.data = o >> (W - len); e.tag = t >> (W - len); e.status = ST_PROTO;
    end
    return e;
  endfunction

  task automatic clear_caps();
    cap_key = '0; cap_nonce = '0; cap_ad = '0; cap_data = '0;
    start_cnt = 0;
  endtask

  // Issue one request; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] k, input logic [W-1:0] n, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic dec);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("req_ready_before_send", req_ready, 1);
    clear_caps();
    req_key = k; req_nonce = n; req_ad = a; req_data = d; req_decrypt = dec;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for rsp_valid (bounded), compare against the scoreboard, handshake.
  task automatic await_rsp(input string tag, output int cyc);
    exp_t e;
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, rsp_data, e.data);
      check({tag, "_tag"}, rsp_tag, e.tag);
      check({tag, "_status"}, rsp_status, e.status);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_cleared"}, rsp_valid, 0);
    check({tag, "_req_ready_back"}, req_ready, 1);
  endtask

  task automatic check_ops(input string tag, input logic [W-1:0] k, input logic [W-1:0] n,
                           input logic [W-1:0] a, input logic [W-1:0] d);
    check({tag, "_start_cycles"}, start_cnt, W);
    check({tag, "_key_bits"}, cap_key, k);
    check({tag, "_nonce_bits"}, cap_nonce, n);
    check({tag, "_ad_bits"}, cap_ad, a);
    check({tag, "_data_bits"}, cap_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   cyc;
    int   len;
    logic stable_ok;
    logic seen_valid;
    exp_t e;
    logic [W-1:0] k, n, a, d, o, t;
    logic dec;

    rst = 1'b1;
    req_valid = 1'b0; req_decrypt = 1'b0; rsp_ready = 1'b0;
    req_key = '0; req_nonce = '0; req_ad = '0; req_data = '0;
    set_core(0, 0, '0, '0);
    clear_caps();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start_o, 0);
    check("rst_core_bits", {core_key_o, core_nonce_o, core_ad_o, core_data_o, core_decrypt_o}, 0);
    check("rst_rsp_fields", {rsp_data, rsp_tag, rsp_status}, 0);

    // Basic encrypt, 3-cycle core delay, 21-cycle latency
    set_core(3, W, 8'h5A, 8'hC3);
    sb.push_back(model(W, 8'h5A, 8'hC3));
    send(8'hA5, 8'h3C, 8'h0F, 8'h81, 1'b0);
    check("basic_busy", busy, 1);
    check("basic_start", core_start_o, 1);
    check("basic_mode", core_decrypt_o, 0);
    await_rsp("basic", cyc);
    check("basic_latency", cyc, 21);
    check_ops("basic", 8'hA5, 8'h3C, 8'h0F, 8'h81);

    // Core never answers: timeout after exactly TIMEOUT WAIT cycles
    set_core(0, 0, '0, '0);
    sb.push_back(model(0, '0, '0));
    send(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    await_rsp("timeout", cyc);
    check("timeout_latency", cyc, W + TIMEOUT);

    // Ready first seen on the last WAIT cycle still succeeds
    set_core(TIMEOUT - 3, W, 8'h96, 8'h69);
    sb.push_back(model(W, 8'h96, 8'h69));
    send(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    await_rsp("edge_timeout", cyc);
    check("edge_timeout_latency", cyc, 2 * W + TIMEOUT - 1);

    // Ready drops after 5 bits: protocol error with partial result
    set_core(2, 5, 8'hFF, 8'hA0);
    sb.push_back(model(5, 8'hFF, 8'hA0));
    send(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
    await_rsp("proto", cyc);
    check("proto_data_literal", rsp_data, 8'h1F);

    // Response held for 10 cycles while a decrypt request waits
    set_core(1, W, 8'h33, 8'hCC);
    e = model(W, 8'h33, 8'hCC);
    sb.push_back(e);
    send(8'h5C, 8'hC5, 8'h99, 8'h66, 1'b0);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    set_core(0, W, 8'h71, 8'h17);
    clear_caps();
    req_key = 8'hF0; req_nonce = 8'h0F; req_ad = 8'hAA; req_data = 8'h55;
    req_decrypt = 1'b1; req_valid = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== e.data ||
          rsp_tag !== e.tag || rsp_status !== e.status)
        stable_ok = 1'b0;
    end
    check("hold_stable", stable_ok, 1);
    sb.push_back(model(W, 8'h71, 8'h17));
    await_rsp("hold", cyc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("hold_second_busy", busy, 1);
    check("hold_second_mode", core_decrypt_o, 1);
    await_rsp("second", cyc);
    check_ops("second", 8'hF0, 8'h0F, 8'hAA, 8'h55);
    check("second_mode_cleared", core_decrypt_o, 0);

    // Asynchronous reset in the middle of LOAD
    set_core(0, W, 8'hAB, 8'hCD);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_flags", {rsp_valid, busy, core_start_o, core_decrypt_o}, 0);
    check("mid_rst_core_bits", {core_key_o, core_nonce_o, core_ad_o, core_data_o}, 0);
    check("mid_rst_rsp_fields", {rsp_data, rsp_tag, rsp_status}, 0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_rsp", seen_valid, 0);
    set_core(2, W, 8'hE7, 8'h7E);
    sb.push_back(model(W, 8'hE7, 8'h7E));
    send(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    await_rsp("after_rst", cyc);
    check_ops("after_rst", 8'h12, 8'h34, 8'h56, 8'h78);

    // Back-to-back randomised transactions
    for (int r = 0; r < 5; r++) begin
      k = 8'($urandom); n = 8'($urandom); a = 8'($urandom); d = 8'($urandom);
      o = 8'($urandom); t = 8'($urandom); dec = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       len = W + $urandom_range(0, 3);
        1:       len = 0;
        default: len = $urandom_range(1, W - 1);
      endcase
      set_core($urandom_range(0, TIMEOUT - 3), len, o, t);
      sb.push_back(model(len, o, t));
      send(k, n, a, d, dec);
      check($sformatf("rand%0d_mode", r), core_decrypt_o, dec);
      await_rsp($sformatf("rand%0d", r), cyc);
      check_ops($sformatf("rand%0d", r), k, n, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
